// File: rtl/pixel_distributor.sv
// Raster-scans a frame and hands pixel coordinates to NUM_ENGINES engines over the x0/y0 -> xpixel/ypixel echo handshake.
// Optional feature macro: PIXEL_DISTRIBUTOR_STALL_CNT_EN adds the stall_cycles counter output.
module pixel_distributor #(
  parameter int NUM_ENGINES      = 4,
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int FRAME_WIDTH      = 640,
  parameter int FRAME_HEIGHT     = 480
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [NUM_ENGINES-1:0]                  eng_en_pixel_map,
  input  logic [NUM_ENGINES-1:0]                  eng_ready,
  input  logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0] eng_xpixel,
  input  logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0] eng_ypixel,
  output logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0] eng_x0,
  output logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0] eng_y0,
  output logic                                    busy,
  output logic                                    frame_done,
  output logic [19:0]                             pixels_issued
`ifdef PIXEL_DISTRIBUTOR_STALL_CNT_EN
  ,
  output logic [31:0]                             stall_cycles
`endif
);

  localparam int N   = NUM_ENGINES;
  localparam int PDW = PIXEL_DATA_WIDTH;
  localparam int PW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t         state;
  logic [N-1:0]   valid;
  logic [N-1:0]   stale;
  logic [N-1:0]   seen_low;
  logic [PW-1:0]  rr_ptr;
  logic [PDW-1:0] cx;
  logic [PDW-1:0] cy;
  logic           load_en;

  logic [N-1:0]   accept;
  logic [4:0]     acc_cnt;
  logic           load;
  logic [PW-1:0]  load_idx;
  int             j;
  logic [PDW-1:0] sel_xpix;
  logic [PDW-1:0] sel_ypix;
  logic           last_pix;
  logic [20:0]    issued_sum;

  // Handshake: a slot is taken once its engine raises en_pixel_map while echoing
  // the slot coordinate; a stale slot also needs en_pixel_map seen low first.
  always_comb begin
    accept  = '0;
    acc_cnt = '0;
    for (int i = 0; i < N; i++) begin
      accept[i] = valid[i] && eng_en_pixel_map[i]
                  && (eng_xpixel[i*PDW +: PDW] == eng_x0[i*PDW +: PDW])
                  && (eng_ypixel[i*PDW +: PDW] == eng_y0[i*PDW +: PDW])
                  && (!stale[i] || seen_low[i]);
      acc_cnt = acc_cnt + 5'(accept[i]);
    end
  end

  // Round-robin pick over pre-accept slot state, so a freed slot waits a cycle.
  always_comb begin
    load     = 1'b0;
    load_idx = '0;
    j        = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(rr_ptr) + k) % N;
      if (!load && state == SCAN && load_en && !valid[j] && eng_ready[j]) begin
        load     = 1'b1;
        load_idx = j[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_xpix   = eng_xpixel[int'(load_idx)*PDW +: PDW];
    sel_ypix   = eng_ypixel[int'(load_idx)*PDW +: PDW];
    last_pix   = (cx == PDW'(FRAME_WIDTH - 1)) && (cy == PDW'(FRAME_HEIGHT - 1));
    issued_sum = {1'b0, pixels_issued} + 21'(acc_cnt);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      valid         <= '0;
      stale         <= '0;
      seen_low      <= '0;
      rr_ptr        <= '0;
      cx            <= '0;
      cy            <= '0;
      load_en       <= 1'b0;
      eng_x0        <= '0;
      eng_y0        <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      pixels_issued <= '0;
`ifdef PIXEL_DISTRIBUTOR_STALL_CNT_EN
      stall_cycles  <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      for (int i = 0; i < N; i++) begin
        if (valid[i] && !eng_en_pixel_map[i]) seen_low[i] <= 1'b1;
        if (accept[i]) valid[i] <= 1'b0;
      end
      pixels_issued <= issued_sum[20] ? 20'hFFFFF : issued_sum[19:0];

      if (load) begin
        valid[load_idx]                      <= 1'b1;
        seen_low[load_idx]                   <= 1'b0;
        stale[load_idx]                      <= (sel_xpix == cx) && (sel_ypix == cy);
        eng_x0[int'(load_idx)*PDW +: PDW]    <= cx;
        eng_y0[int'(load_idx)*PDW +: PDW]    <= cy;
        rr_ptr <= (load_idx == PW'(N - 1)) ? '0 : load_idx + PW'(1);
        if (cx == PDW'(FRAME_WIDTH - 1)) begin
          cx <= '0;
          cy <= cy + PDW'(1);
        end else begin
          cx <= cx + PDW'(1);
        end
      end

`ifdef PIXEL_DISTRIBUTOR_STALL_CNT_EN
      if (state == SCAN && !load) stall_cycles <= stall_cycles + 32'd1;
`endif

      case (state)
        IDLE: if (start) begin
          state         <= SCAN;
          busy          <= 1'b1;
          cx            <= '0;
          cy            <= '0;
          load_en       <= 1'b0;
          pixels_issued <= '0;
`ifdef PIXEL_DISTRIBUTOR_STALL_CNT_EN
          stall_cycles  <= '0;
`endif
        end
        SCAN: begin
          load_en <= 1'b1;
          if (load && last_pix) state <= DRAIN;
        end
        DRAIN: if (valid == '0) begin
          state      <= DONE;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_distributor.sv
// Randomized bench for pixel_distributor: a pixel-index reference model predicts every output each cycle.
module tb_pixel_distributor;

  localparam int N   = 4;
  localparam int PDW = 10;
  localparam int W   = 6;
  localparam int H   = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [N-1:0]       en;
  logic [N-1:0]       ready;
  logic [N*PDW-1:0]   xp;
  logic [N*PDW-1:0]   yp;
  logic [N*PDW-1:0]   x0;
  logic [N*PDW-1:0]   y0;
  logic               busy;
  logic               frame_done;
  logic [19:0]        pixels_issued;
`ifdef PIXEL_DISTRIBUTOR_STALL_CNT_EN
  logic [31:0]        stall_cycles;
`endif

  pixel_distributor #(
    .NUM_ENGINES(N), .PIXEL_DATA_WIDTH(PDW), .FRAME_WIDTH(W), .FRAME_HEIGHT(H)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .eng_en_pixel_map(en), .eng_ready(ready),
    .eng_xpixel(xp), .eng_ypixel(yp),
    .eng_x0(x0), .eng_y0(y0),
    .busy(busy), .frame_done(frame_done), .pixels_issued(pixels_issued)
`ifdef PIXEL_DISTRIBUTOR_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model. Phases: 0 idle, 1 scan setup cycle, 2 scan loading, 3 drain, 4 done.
  int          m_phase;
  int          m_pix;
  int          m_rr;
  int          m_issued;
  int unsigned m_stall;
  int          m_x[N];
  int          m_y[N];
  bit          m_valid[N];
  bit          m_stale[N];
  bit          m_seen[N];
  bit          pre_valid[N];
  int          acc;
  int          ld;
  int          any_valid;
  int          ex;
  int          ey;

  always @(posedge clk) begin
    if (!reset) begin
      m_phase = 0; m_rr = 0; m_issued = 0; m_stall = 0; m_pix = 0;
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 0; m_x[i] = 0; m_y[i] = 0; m_stale[i] = 0; m_seen[i] = 0;
      end
    end else begin
      acc = 0; ld = -1; any_valid = 0;
      for (int i = 0; i < N; i++) begin
        pre_valid[i] = m_valid[i];
        if (m_valid[i]) any_valid = 1;
      end
      if (m_phase == 2)
        for (int k = 0; k < N; k++)
          if (ld < 0 && !pre_valid[(m_rr + k) % N] && ready[(m_rr + k) % N]) ld = (m_rr + k) % N;
      for (int i = 0; i < N; i++) begin
        ex = int'(xp[i*PDW +: PDW]);
        ey = int'(yp[i*PDW +: PDW]);
        if (pre_valid[i] && en[i] && ex == m_x[i] && ey == m_y[i] && (!m_stale[i] || m_seen[i])) begin
          acc++;
          m_valid[i] = 0;
        end
        if (pre_valid[i] && !en[i]) m_seen[i] = 1;
      end
      m_issued = (m_issued + acc > 20'hFFFFF) ? 20'hFFFFF : m_issued + acc;
      if (ld >= 0) begin
        m_x[ld]     = m_pix % W;
        m_y[ld]     = m_pix / W;
        m_stale[ld] = (int'(xp[ld*PDW +: PDW]) == m_x[ld]) && (int'(yp[ld*PDW +: PDW]) == m_y[ld]);
        m_seen[ld]  = 0;
        m_valid[ld] = 1;
        m_rr        = (ld + 1) % N;
        m_pix++;
      end
      case (m_phase)
        0: if (start) begin m_phase = 1; m_pix = 0; m_issued = 0; m_stall = 0; end
        1: begin m_stall++; m_phase = 2; end
        2: begin
          if (ld < 0) m_stall++;
          if (m_pix == W * H) m_phase = 3;
        end
        3: if (!any_valid) m_phase = 4;
        default: m_phase = 0;
      endcase
    end
  end

  int done_seen = 0;

  task automatic check_outputs();
    for (int i = 0; i < N; i++) begin
      check($sformatf("x0[%0d]", i), 32'(x0[i*PDW +: PDW]), 32'(m_x[i]));
      check($sformatf("y0[%0d]", i), 32'(y0[i*PDW +: PDW]), 32'(m_y[i]));
    end
    check("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 3));
    check("frame_done", 32'(frame_done), 32'(m_phase == 4));
    check("pixels_issued", 32'(pixels_issued), 32'(m_issued));
`ifdef PIXEL_DISTRIBUTOR_STALL_CNT_EN
    check("stall_cycles", stall_cycles, m_stall);
`endif
    if (frame_done) done_seen++;
  endtask

  task automatic drive_random(input logic [N-1:0] mask, input bit hold_ready);
    for (int i = 0; i < N; i++) begin
      ready[i] = !hold_ready && mask[i] && ($urandom_range(0, 4) != 0);
      en[i]    = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) != 0) begin
        xp[i*PDW +: PDW] = PDW'(m_x[i]);
        yp[i*PDW +: PDW] = PDW'(m_y[i]);
      end else begin
        xp[i*PDW +: PDW] = PDW'($urandom_range(0, W - 1));
        yp[i*PDW +: PDW] = PDW'($urandom_range(0, H - 1));
      end
    end
    start = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    logic [N-1:0] mask;
    int hold;
    int cyc;
    reset = 1'b0; start = 1'b0; en = '0; ready = '0; xp = '0; yp = '0;
    repeat (3) @(negedge clk);
    check_outputs();
    reset = 1'b1;
    @(negedge clk);
    check_outputs();

    for (int f = 0; f < 10; f++) begin
      mask = (f == 2) ? 4'b1101 : 4'b1111;
      hold = (f == 3) ? 10 : 0;
      drive_random(mask, hold > 0);
      start = 1'b1;
      reset = 1'b1;
      cyc   = 0;
      while (1) begin
        @(negedge clk);
        cyc++;
        check_outputs();
        if (m_phase == 0 && cyc > 1) break;
        if (cyc > 2000) begin
          check("frame_timeout", 32'(cyc), 32'd2000);
          break;
        end
        drive_random(mask, cyc < hold);
        reset = !(f == 5 && cyc == 8);
      end
    end
    check("frame_done_count", 32'(done_seen), 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
